// File: rtl/big_alu_pkg.sv
// Shared definitions for the big-ALU design.
// Contents:
//   - op_e: 4-bit opcode enumeration (ADD..CLR)
//   - operand-source select codes for the A and B muxes
//   - instr_t: the packed view of the 16-bit instruction word
//       [15:12] op, [11] en, [10:9] dst, [8:7] asel, [6:5] bsel, [4:0] imm
package big_alu_pkg;

  localparam int NREG    = 4;
  localparam int INSTR_W = 16;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_NOT   = 4'h5,
    OP_SHL   = 4'h6,
    OP_SHR   = 4'h7,
    OP_MUL   = 4'h8,
    OP_CMP   = 4'h9,
    OP_PASSA = 4'hA,
    OP_PASSB = 4'hB,
    OP_INC   = 4'hC,
    OP_DEC   = 4'hD,
    OP_ASR   = 4'hE,
    OP_CLR   = 4'hF
  } op_e;

  // A operand sources
  localparam logic [1:0] SRC_A_DATA0 = 2'b00;
  localparam logic [1:0] SRC_A_DATA1 = 2'b01;
  localparam logic [1:0] SRC_A_REG   = 2'b10;
  localparam logic [1:0] SRC_A_ZERO  = 2'b11;

  // B operand sources
  localparam logic [1:0] SRC_B_DATA1 = 2'b00;
  localparam logic [1:0] SRC_B_DATA0 = 2'b01;
  localparam logic [1:0] SRC_B_REG   = 2'b10;
  localparam logic [1:0] SRC_B_IMM   = 2'b11;

  typedef struct packed {
    op_e        op;
    logic       en;
    logic [1:0] dst;
    logic [1:0] asel;
    logic [1:0] bsel;
    logic [4:0] imm;
  } instr_t;

endpackage

// File: rtl/big_alu_core.sv
// Purely combinational ALU datapath.
// Ports:
//   op      in  opcode
//   a, b    in  W-bit operands
//   res_lo  out W-bit result (low half of the product for MUL)
//   res_hi  out high half of the product for MUL, zero otherwise
//   of      out carry / borrow / shifted-out / product-overflow flag
//   zf      out zero flag (full 2W-bit product for MUL, forced 1 for CLR)
module big_alu_core
  import big_alu_pkg::*;
#(
  parameter int W = 8
) (
  input  op_e          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res_lo,
  output logic [W-1:0] res_hi,
  output logic         of,
  output logic         zf
);

  logic [2:0]     sh;
  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] shl_wide;
  logic [W-1:0]   asr;

  // Shifts only honour the low three bits of B.
  assign sh = b[2:0];

  // One extra bit on the add/subtract captures carry and borrow directly.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};

  // Left shift into a double-width word so the bits pushed out stay visible.
  assign shl_wide = {{W{1'b0}}, a} << sh;
  assign asr      = $signed(a) >>> sh;

  always_comb begin
    res_lo = '0;
    res_hi = '0;
    of     = 1'b0;
    case (op)
      OP_ADD: begin
        res_lo = sum[W-1:0];
        of     = sum[W];
      end
      OP_SUB, OP_CMP: begin
        res_lo = diff[W-1:0];
        of     = diff[W];
      end
      OP_AND:   res_lo = a & b;
      OP_OR:    res_lo = a | b;
      OP_XOR:   res_lo = a ^ b;
      OP_NOT:   res_lo = ~a;
      OP_SHL: begin
        res_lo = shl_wide[W-1:0];
        of     = |shl_wide[2*W-1:W];
      end
      OP_SHR:   res_lo = a >> sh;
      OP_MUL: begin
        res_lo = prod[W-1:0];
        res_hi = prod[2*W-1:W];
        of     = |prod[2*W-1:W];
      end
      OP_PASSA: res_lo = a;
      OP_PASSB: res_lo = b;
      OP_INC: begin
        res_lo = a + 1'b1;
        of     = &a;
      end
      OP_DEC: begin
        res_lo = a - 1'b1;
        of     = ~|a;
      end
      OP_ASR:   res_lo = asr;
      OP_CLR:   res_lo = '0;
      default:  res_lo = '0;
    endcase

    // MUL judges zero on the whole product; CLR always reports zero.
    zf = (res_lo == '0);
    if (op == OP_MUL) begin
      zf = (prod == '0);
    end else if (op == OP_CLR) begin
      zf = 1'b1;
    end
  end

endmodule

// File: rtl/big_alu_top.sv
// Registered 8-bit ALU with four output registers and registered flags.
// Each enabled instruction selects A and B operands, runs them through
// big_alu_core and writes the result to R[dst] one clock later.
// Ports:
//   clk          in  rising-edge clock
//   rst          in  asynchronous active-high reset
//   instruction  in  16-bit instruction word (see big_alu_pkg::instr_t)
//   data0, data1 in  external operands
//   out0..out3   out registers R0..R3
//   of, zf       out registered overflow and zero flags
module big_alu_top
  import big_alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  instruction,
  input  logic [W-1:0] data0,
  input  logic [W-1:0] data1,
  output logic [W-1:0] out0,
  output logic [W-1:0] out1,
  output logic [W-1:0] out2,
  output logic [W-1:0] out3,
  output logic         of,
  output logic         zf
);

  instr_t                   instr;
  logic [NREG-1:0][W-1:0]   regs;
  logic [W-1:0]             a_val;
  logic [W-1:0]             b_val;
  logic [W-1:0]             res_lo;
  logic [W-1:0]             res_hi;
  logic                     alu_of;
  logic                     alu_zf;
  logic [1:0]               dst_next;

  assign instr = instr_t'(instruction);

  // Register sources read the pre-write value, giving read-modify-write in one cycle.
  always_comb begin
    a_val = '0;
    case (instr.asel)
      SRC_A_DATA0: a_val = data0;
      SRC_A_DATA1: a_val = data1;
      SRC_A_REG:   a_val = regs[instr.dst];
      SRC_A_ZERO:  a_val = '0;
      default:     a_val = '0;
    endcase
  end

  always_comb begin
    b_val = '0;
    case (instr.bsel)
      SRC_B_DATA1: b_val = data1;
      SRC_B_DATA0: b_val = data0;
      SRC_B_REG:   b_val = regs[instr.dst];
      SRC_B_IMM:   b_val = {{(W-5){1'b0}}, instr.imm};
      default:     b_val = '0;
    endcase
  end

  big_alu_core #(.W(W)) u_core (
    .op     (instr.op),
    .a      (a_val),
    .b      (b_val),
    .res_lo (res_lo),
    .res_hi (res_hi),
    .of     (alu_of),
    .zf     (alu_zf)
  );

  // The high half of a product lands in the next register, R3 wrapping to R0.
  assign dst_next = instr.dst + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
      of   <= 1'b0;
      zf   <= 1'b0;
    end else if (instr.en) begin
      of <= alu_of;
      zf <= alu_zf;
      case (instr.op)
        OP_CLR: regs <= '0;
        OP_MUL: begin
          regs[instr.dst] <= res_lo;
          regs[dst_next]  <= res_hi;
        end
        OP_CMP: ;
        default: regs[instr.dst] <= res_lo;
      endcase
    end
  end

  assign out0 = regs[0];
  assign out1 = regs[1];
  assign out2 = regs[2];
  assign out3 = regs[3];

endmodule

// File: tb/tb_big_alu_top.sv
// Self-checking bench for big_alu_top: a table of hand-computed vectors
// driven through a scoreboard queue, then a reset-during-operation sequence.
module tb_big_alu_top;

  typedef struct {
    string       name;
    logic [15:0] instr;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [7:0]  o0;
    logic [7:0]  o1;
    logic [7:0]  o2;
    logic [7:0]  o3;
    logic        of;
    logic        zf;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [15:0] instruction;
  logic [7:0]  data0;
  logic [7:0]  data1;
  logic [7:0]  out0;
  logic [7:0]  out1;
  logic [7:0]  out2;
  logic [7:0]  out3;
  logic        of;
  logic        zf;

  int n_checks;
  int n_fail;

  vec_t vec_tab[$];
  vec_t exp_q[$];

  big_alu_top #(.W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .data0       (data0),
    .data1       (data1),
    .out0        (out0),
    .out1        (out1),
    .out2        (out2),
    .out3        (out3),
    .of          (of),
    .zf          (zf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [15:0] mk(input logic [3:0] op, input logic en,
                                     input logic [1:0] dst, input logic [1:0] asel,
                                     input logic [1:0] bsel, input logic [4:0] imm);
    return {op, en, dst, asel, bsel, imm};
  endfunction

  task automatic addVec(input string name, input logic [15:0] instr,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] o0, input logic [7:0] o1,
                        input logic [7:0] o2, input logic [7:0] o3,
                        input logic f_of, input logic f_zf);
    vec_t v;
    v.name = name; v.instr = instr; v.d0 = d0; v.d1 = d1;
    v.o0 = o0; v.o1 = o1; v.o2 = o2; v.o3 = o3; v.of = f_of; v.zf = f_zf;
    vec_tab.push_back(v);
  endtask

  task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic checkOutput(input vec_t e);
    checkVal({e.name, " out0"}, out0, e.o0);
    checkVal({e.name, " out1"}, out1, e.o1);
    checkVal({e.name, " out2"}, out2, e.o2);
    checkVal({e.name, " out3"}, out3, e.o3);
    checkVal({e.name, " of"}, {7'b0, of}, {7'b0, e.of});
    checkVal({e.name, " zf"}, {7'b0, zf}, {7'b0, e.zf});
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    instruction = v.instr;
    data0       = v.d0;
    data1       = v.d1;
    exp_q.push_back(v);
  endtask

  task automatic popAndCheck();
    vec_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard: queue empty, got nothing, expected an entry");
    end else begin
      e = exp_q.pop_front();
      checkOutput(e);
    end
  endtask

  initial begin
    vec_t zero_v;
    vec_t v;
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    instruction = 16'h0000;
    data0       = 8'h00;
    data1       = 8'h00;

    zero_v.name = "reset"; zero_v.instr = 16'h0; zero_v.d0 = 8'h0; zero_v.d1 = 8'h0;
    zero_v.o0 = 8'h0; zero_v.o1 = 8'h0; zero_v.o2 = 8'h0; zero_v.o3 = 8'h0;
    zero_v.of = 1'b0; zero_v.zf = 1'b0;

    //       name        instruction                 d0     d1     out0   out1   out2   out3   of    zf
    addVec("nop0",     16'h0000,                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    addVec("clr",      16'hFFFF,                   8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    addVec("add1+1",   16'h0800,                   8'd1,  8'd1,  8'd2,  8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    addVec("add75+1",  16'h0800,                   8'd75, 8'd1,  8'd76, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    addVec("add75+25", 16'h0800,                   8'd75, 8'd25, 8'd100,8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    addVec("addcarry", 16'h0800,                   8'd200,8'd100,8'd44, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    addVec("sub5-5",   mk(4'h1,1,2'd0,2'd0,2'd0,0),8'd5,  8'd5,  8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    addVec("mulwrap",  mk(4'h8,1,2'd3,2'd0,2'd0,0),8'hFF, 8'hFF, 8'hFE, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
    addVec("en0",      mk(4'h0,0,2'd1,2'd0,2'd0,0),8'h07, 8'h07, 8'hFE, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
    addVec("shlout",   mk(4'h6,1,2'd1,2'd0,2'd3,3),8'hF1, 8'h00, 8'hFE, 8'h88, 8'h00, 8'h01, 1'b1, 1'b0);
    addVec("shlmask",  mk(4'h6,1,2'd1,2'd0,2'd3,9),8'h40, 8'h00, 8'hFE, 8'h80, 8'h00, 8'h01, 1'b0, 1'b0);
    addVec("asr",      mk(4'hE,1,2'd2,2'd0,2'd3,2),8'h84, 8'h00, 8'hFE, 8'h80, 8'hE1, 8'h01, 1'b0, 1'b0);
    addVec("shrreg",   mk(4'h7,1,2'd2,2'd2,2'd1,0),8'h0A, 8'h00, 8'hFE, 8'h80, 8'h38, 8'h01, 1'b0, 1'b0);
    addVec("incwrap",  mk(4'hC,1,2'd3,2'd0,2'd0,0),8'hFF, 8'h00, 8'hFE, 8'h80, 8'h38, 8'h00, 1'b1, 1'b1);
    addVec("dec0",     mk(4'hD,1,2'd3,2'd3,2'd0,0),8'h00, 8'h00, 8'hFE, 8'h80, 8'h38, 8'hFF, 1'b1, 1'b0);
    addVec("cmplt",    mk(4'h9,1,2'd0,2'd0,2'd0,0),8'd3,  8'd7,  8'hFE, 8'h80, 8'h38, 8'hFF, 1'b1, 1'b0);
    addVec("cmpeq",    mk(4'h9,1,2'd0,2'd0,2'd0,0),8'd9,  8'd9,  8'hFE, 8'h80, 8'h38, 8'hFF, 1'b0, 1'b1);
    addVec("xorreg",   mk(4'h4,1,2'd0,2'd2,2'd0,0),8'h00, 8'h0F, 8'hF1, 8'h80, 8'h38, 8'hFF, 1'b0, 1'b0);
    addVec("not",      mk(4'h5,1,2'd1,2'd1,2'd0,0),8'h00, 8'hF0, 8'hF1, 8'h0F, 8'h38, 8'hFF, 1'b0, 1'b0);
    addVec("and",      mk(4'h2,1,2'd2,2'd0,2'd0,0),8'h3C, 8'h0F, 8'hF1, 8'h0F, 8'h0C, 8'hFF, 1'b0, 1'b0);
    addVec("orzero",   mk(4'h3,1,2'd2,2'd3,2'd3,0),8'hAA, 8'h55, 8'hF1, 8'h0F, 8'h00, 8'hFF, 1'b0, 1'b1);
    addVec("passbreg", mk(4'hB,1,2'd3,2'd0,2'd2,0),8'h11, 8'h22, 8'hF1, 8'h0F, 8'h00, 8'hFF, 1'b0, 1'b0);
    addVec("passa",    mk(4'hA,1,2'd1,2'd1,2'd0,0),8'h00, 8'h5A, 8'hF1, 8'h5A, 8'h00, 8'hFF, 1'b0, 1'b0);
    addVec("mullo0",   mk(4'h8,1,2'd1,2'd0,2'd0,0),8'h10, 8'h10, 8'hF1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    addVec("mulzero",  mk(4'h8,1,2'd0,2'd0,2'd0,0),8'h00, 8'h05, 8'h00, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1);
    addVec("subborrow",mk(4'h1,1,2'd2,2'd0,2'd3,5'h1F),8'h10,8'h00,8'h00, 8'h00, 8'hF1, 8'hFF, 1'b1, 1'b0);
    addVec("clren0",   16'hF7FF,                   8'h00, 8'h00, 8'h00, 8'h00, 8'hF1, 8'hFF, 1'b1, 1'b0);
    addVec("clrdata",  16'hFFFF,                   8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    addVec("pre_rst",  16'h0800,                   8'd3,  8'd4,  8'd7,  8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

    // Reset state while rst is held
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput(zero_v);
    rst = 1'b0;

    // Table-driven vectors through the scoreboard
    for (int i = 0; i < vec_tab.size(); i++) begin
      applyStimulus(vec_tab[i]);
      popAndCheck();
    end

    // Reset asserted between edges with an enabled ADD pending
    @(negedge clk);
    instruction = 16'h0800;
    data0       = 8'd10;
    data1       = 8'd20;
    #2;
    rst = 1'b1;
    #1;
    zero_v.name = "rst_async";
    checkOutput(zero_v);
    @(posedge clk);
    #1;
    zero_v.name = "rst_held";
    checkOutput(zero_v);
    @(negedge clk);
    rst = 1'b0;
    v = zero_v;
    v.name = "post_rst";
    v.o0   = 8'd30;
    exp_q.push_back(v);
    popAndCheck();

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
